approx_error_monitor: RTL

//  Exhaustive sweep driver and error checker for one 4-input approximate SOP circuit.
//  - Drives every input vector into the approximate circuit and its exact reference

---
 rtl/approx_error_monitor_pkg.sv | 26 ++
 rtl/abs_err_unit.sv | 19 +
 rtl/approx_error_monitor.sv | 123 ++++++++++++
 3 files changed

// File: rtl/approx_error_monitor_pkg.sv
// rtl/approx_error_monitor_pkg.sv - shared state enum, drain length and width helpers
package approx_error_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SWEEP,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam int DRAIN_CYCLES = 2;

  function automatic int err_w(input int out_w);
    return out_w;
  endfunction

  // Wide enough for (2**out_w - 1) * 2**n_in
  function automatic int sum_w(input int n_in, input int out_w);
    return out_w + n_in;
  endfunction

  function automatic int cnt_w(input int n_in);
    return n_in + 1;
  endfunction

endpackage

// File: rtl/abs_err_unit.sv
// rtl/abs_err_unit.sv - unsigned |exact - approx| and strict threshold compare
module abs_err_unit #(
  parameter int          OUT_W = 3,
  parameter int unsigned ET    = 4
) (
  input  logic [OUT_W-1:0] exact,
  input  logic [OUT_W-1:0] approx,
  output logic [OUT_W-1:0] err,
  output logic             viol
);

  always_comb begin
    err = (exact >= approx) ? (exact - approx) : (approx - exact);
  end

  // err equal to ET is still acceptable
  assign viol = (32'(err) > ET);

endmodule

// File: rtl/approx_error_monitor.sv
// rtl/approx_error_monitor.sv - exhaustive sweep driver and error accumulator for an approximate circuit
module approx_error_monitor
  import approx_error_monitor_pkg::*;
#(
  parameter int          N_IN  = 4,
  parameter int          OUT_W = 3,
  parameter int unsigned ET    = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start_i,
  input  logic                             hold_i,
  output logic [N_IN-1:0]                  stim_o,
  output logic                             stim_valid_o,
  input  logic [OUT_W-1:0]                 exact_i,
  input  logic [OUT_W-1:0]                 approx_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic [err_w(OUT_W)-1:0]          max_err_o,
  output logic [sum_w(N_IN, OUT_W)-1:0]    sum_err_o,
  output logic [cnt_w(N_IN)-1:0]           viol_cnt_o,
  output logic [N_IN-1:0]                  first_viol_o,
  output logic                             pass_o
);

  localparam int SUM_W = sum_w(N_IN, OUT_W);
  localparam logic [N_IN-1:0] STIM_LAST = {N_IN{1'b1}};
  localparam logic [1:0] DRAIN_LAST = 2'(DRAIN_CYCLES - 1);

  state_t             state;
  logic [1:0]         drain_cnt;
  logic               s1_valid;
  logic [OUT_W-1:0]   s1_exact;
  logic [OUT_W-1:0]   s1_approx;
  logic [N_IN-1:0]    s1_stim;
  logic [OUT_W-1:0]   s2_err;
  logic               s2_viol;

  abs_err_unit #(
    .OUT_W (OUT_W),
    .ET    (ET)
  ) u_abs_err (
    .exact  (s1_exact),
    .approx (s1_approx),
    .err    (s2_err),
    .viol   (s2_viol)
  );

  assign stim_valid_o = (state == ST_SWEEP) && !hold_i;
  assign busy_o       = (state == ST_SWEEP) || (state == ST_DRAIN);
  assign pass_o       = done_o && (viol_cnt_o == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      drain_cnt    <= '0;
      stim_o       <= '0;
      s1_valid     <= 1'b0;
      s1_exact     <= '0;
      s1_approx    <= '0;
      s1_stim      <= '0;
      done_o       <= 1'b0;
      max_err_o    <= '0;
      sum_err_o    <= '0;
      viol_cnt_o   <= '0;
      first_viol_o <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            state        <= ST_SWEEP;
            stim_o       <= '0;
            s1_valid     <= 1'b0;
            done_o       <= 1'b0;
            max_err_o    <= '0;
            sum_err_o    <= '0;
            viol_cnt_o   <= '0;
            first_viol_o <= '0;
          end
        end
        ST_SWEEP: begin
          s1_valid <= !hold_i;
          if (!hold_i) begin
            s1_exact  <= exact_i;
            s1_approx <= approx_i;
            s1_stim   <= stim_o;
            // The last vector parks stim_o rather than wrapping to zero
            if (stim_o == STIM_LAST) begin
              state     <= ST_DRAIN;
              drain_cnt <= '0;
            end else begin
              stim_o <= stim_o + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          s1_valid <= 1'b0;
          if (drain_cnt == DRAIN_LAST) begin
            state  <= ST_DONE;
            done_o <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (s1_valid) begin
        if (s2_err > max_err_o) begin
          max_err_o <= s2_err;
        end
        sum_err_o <= sum_err_o + SUM_W'(s2_err);
        if (s2_viol) begin
          viol_cnt_o <= viol_cnt_o + 1'b1;
          if (viol_cnt_o == '0) begin
            first_viol_o <= s1_stim;
          end
        end
      end
    end
  end

endmodule
